// File: rtl/nn_inference_sequencer.sv
// rtl/nn_inference_sequencer.sv - run controller: key press to nn_start, result latch, latency and watchdog
module nn_inference_sequencer #(
  parameter int         START_LEN      = 2,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         CNT_W          = 24,
  parameter logic [3:0] BLANK_CODE     = 4'd10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             btn_n,
  input  logic             auto_mode,
  input  logic             clear,
  output logic             nn_start,
  input  logic             nn_done,
  input  logic [3:0]       nn_argmax,
  output logic [3:0]       result,
  output logic             result_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam int               SW         = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [SW-1:0]    START_LAST = SW'(START_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [SW-1:0]    start_cnt;
  logic             sync1, sync2, btn_prev;
  logic [1:0]       rdy;
  logic             done_d;
  logic             press, done_rise, enter_start;
  logic [CNT_W-1:0] cnt_next;

  // btn_prev starts "pressed" and only follows sync2 once the synchronizer holds a
  // real sample, so a key held down through reset never registers as a press.
  assign press     = btn_prev & ~sync2;
  assign done_rise = nn_done & ~done_d;
  assign cnt_next  = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + 1'b1;

  assign enter_start = ~clear & (((state == S_IDLE) & press) |
                                 ((state == S_HOLD) & (press | auto_mode)) |
                                 ((state == S_ERR)  & press));

  assign state_dbg = state;
  assign nn_start  = (state == S_START);
  assign busy      = (state == S_START) | (state == S_RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      start_cnt    <= '0;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      btn_prev     <= 1'b0;
      rdy          <= 2'b00;
      done_d       <= 1'b0;
      result       <= BLANK_CODE;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      cycle_count  <= '0;
    end else begin
      sync1  <= btn_n;
      sync2  <= sync1;
      rdy    <= {rdy[0], 1'b1};
      done_d <= nn_done;
      if (rdy[1]) btn_prev <= sync2;

      if (clear) begin
        state        <= S_IDLE;
        start_cnt    <= '0;
        result       <= BLANK_CODE;
        result_valid <= 1'b0;
        timeout_err  <= 1'b0;
        cycle_count  <= '0;
      end else if (enter_start) begin
        state        <= S_START;
        start_cnt    <= '0;
        result_valid <= 1'b0;
        timeout_err  <= 1'b0;
        cycle_count  <= '0;
      end else begin
        case (state)
          S_START: begin
            cycle_count <= cnt_next;
            if (start_cnt == START_LAST) state <= S_RUN;
            else start_cnt <= start_cnt + 1'b1;
          end
          S_RUN: begin
            cycle_count <= cnt_next;
            // done wins over a watchdog expiry landing on the same cycle
            if (done_rise) begin
              result       <= (nn_argmax <= 4'd9) ? nn_argmax : BLANK_CODE;
              result_valid <= 1'b1;
              state        <= S_HOLD;
            end else if (cycle_count == TO_LAST) begin
              result      <= BLANK_CODE;
              timeout_err <= 1'b1;
              state       <= S_ERR;
            end
          end
          S_IDLE, S_HOLD, S_ERR: state <= state;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// tb/tb_nn_inference_sequencer.sv - directed scenario bench for nn_inference_sequencer
module tb_nn_inference_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        btn_n;
  logic        auto_mode;
  logic        clear;
  logic        nn_start;
  logic        nn_done;
  logic [3:0]  nn_argmax;
  logic [3:0]  result;
  logic        result_valid;
  logic        busy;
  logic        timeout_err;
  logic [23:0] cycle_count;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  nn_inference_sequencer #(
    .START_LEN(2), .TIMEOUT_CYCLES(100), .CNT_W(24), .BLANK_CODE(4'd10)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_n(btn_n), .auto_mode(auto_mode), .clear(clear),
    .nn_start(nn_start), .nn_done(nn_done), .nn_argmax(nn_argmax), .result(result),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err),
    .cycle_count(cycle_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // key down for three edges lands the sequencer in its first START cycle
  task automatic do_press();
    btn_n = 1'b0;
    cyc(3);
    btn_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    resetn = 1'b0; btn_n = 1'b0; nn_done = 1'b1; auto_mode = 1'b0; clear = 1'b0; nn_argmax = 4'd0;
    cyc(3);
    checks++; if (nn_start !== 1'b0) begin failures++; $display("FAIL reset_nn_start got=%0d exp=0", nn_start); end
    checks++; if (result !== 4'd10) begin failures++; $display("FAIL reset_result got=%0d exp=10", result); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", result_valid); end
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    checks++; if (cycle_count !== 24'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL reset_misc got=%0d/%0d/%0d exp=0/0/0", cycle_count, busy, timeout_err);
    end
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (state_dbg !== 3'd0 || nn_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL held_key_after_reset got=%0d bad_cycles exp=0", bad); end
    btn_n = 1'b1; nn_done = 1'b0;
    cyc(4);
  endtask

  task automatic test_press_latency();
    int first, cnt;
    first = 0; cnt = 0;
    btn_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (nn_start === 1'b1) begin
        if (first == 0) first = i;
        cnt++;
      end
    end
    checks++; if (first != 3) begin failures++; $display("FAIL start_latency got=%0d exp=3", first); end
    checks++; if (cnt != 2) begin failures++; $display("FAIL start_len got=%0d exp=2", cnt); end
    checks++; if (state_dbg !== 3'd2) begin failures++; $display("FAIL held_key_state got=%0d exp=2", state_dbg); end
    btn_n = 1'b1; clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    checks++; if (state_dbg !== 3'd0 || result !== 4'd10) begin
      failures++; $display("FAIL clear_from_run got=%0d/%0d exp=0/10", state_dbg, result);
    end
    cyc(3);
  endtask

  task automatic test_run_result();
    do_press();
    cyc(2);
    checks++; if (state_dbg !== 3'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL run_entry got=%0d/%0d exp=2/1", state_dbg, busy);
    end
    cyc(49);
    nn_done = 1'b1; nn_argmax = 4'd7;
    cyc(1);
    checks++; if (result !== 4'd7) begin failures++; $display("FAIL run_result got=%0d exp=7", result); end
    checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL run_valid got=%0d exp=1", result_valid); end
    checks++; if (cycle_count !== 24'd52) begin failures++; $display("FAIL run_count got=%0d exp=52", cycle_count); end
    checks++; if (state_dbg !== 3'd3 || busy !== 1'b0) begin
      failures++; $display("FAIL run_hold got=%0d/%0d exp=3/0", state_dbg, busy);
    end
    cyc(3);
    nn_done = 1'b0;
    checks++; if (cycle_count !== 24'd52 || state_dbg !== 3'd3) begin
      failures++; $display("FAIL hold_freeze got=%0d/%0d exp=52/3", cycle_count, state_dbg);
    end
  endtask

  task automatic test_timeout();
    do_press();
    checks++; if (state_dbg !== 3'd1 || result_valid !== 1'b0 || result !== 4'd7) begin
      failures++; $display("FAIL restart_from_hold got=%0d/%0d/%0d exp=1/0/7", state_dbg, result_valid, result);
    end
    cyc(99);
    checks++; if (state_dbg !== 3'd2 || cycle_count !== 24'd99) begin
      failures++; $display("FAIL pre_timeout got=%0d/%0d exp=2/99", state_dbg, cycle_count);
    end
    cyc(1);
    checks++; if (state_dbg !== 3'd4 || timeout_err !== 1'b1) begin
      failures++; $display("FAIL timeout_err got=%0d/%0d exp=4/1", state_dbg, timeout_err);
    end
    checks++; if (result !== 4'd10 || cycle_count !== 24'd100) begin
      failures++; $display("FAIL timeout_vals got=%0d/%0d exp=10/100", result, cycle_count);
    end
    auto_mode = 1'b1;
    cyc(3);
    auto_mode = 1'b0;
    checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL err_no_auto got=%0d exp=4", state_dbg); end
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    checks++; if (state_dbg !== 3'd0 || timeout_err !== 1'b0 || cycle_count !== 24'd0) begin
      failures++; $display("FAIL err_clear got=%0d/%0d/%0d exp=0/0/0", state_dbg, timeout_err, cycle_count);
    end
  endtask

  task automatic test_blank_and_auto();
    do_press();
    cyc(2);
    nn_done = 1'b1; nn_argmax = 4'd12;
    cyc(1);
    checks++; if (result !== 4'd10 || result_valid !== 1'b1 || cycle_count !== 24'd3) begin
      failures++; $display("FAIL blank_capture got=%0d/%0d/%0d exp=10/1/3", result, result_valid, cycle_count);
    end
    auto_mode = 1'b1;
    cyc(1);
    checks++; if (state_dbg !== 3'd1 || nn_start !== 1'b1 || result_valid !== 1'b0) begin
      failures++; $display("FAIL auto_restart got=%0d/%0d/%0d exp=1/1/0", state_dbg, nn_start, result_valid);
    end
    checks++; if (result !== 4'd10 || cycle_count !== 24'd0) begin
      failures++; $display("FAIL auto_keep_result got=%0d/%0d exp=10/0", result, cycle_count);
    end
    auto_mode = 1'b0; nn_done = 1'b0;
    cyc(2);
    nn_done = 1'b1; nn_argmax = 4'd5;
    cyc(1);
    nn_done = 1'b0;
    checks++; if (result !== 4'd5 || state_dbg !== 3'd3) begin
      failures++; $display("FAIL recapture got=%0d/%0d exp=5/3", result, state_dbg);
    end
  endtask

  task automatic test_clear_vs_press();
    btn_n = 1'b0;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    checks++; if (state_dbg !== 3'd0 || nn_start !== 1'b0 || result !== 4'd10 || result_valid !== 1'b0) begin
      failures++; $display("FAIL clear_beats_press got=%0d/%0d/%0d/%0d exp=0/0/10/0",
                           state_dbg, nn_start, result, result_valid);
    end
    cyc(5);
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL clear_no_requeue got=%0d exp=0", state_dbg); end
    btn_n = 1'b1;
    cyc(4);
  endtask

  task automatic test_press_in_run_and_reset();
    do_press();
    cyc(2);
    btn_n = 1'b0;
    cyc(5);
    btn_n = 1'b1;
    cyc(4);
    checks++; if (state_dbg !== 3'd2 || cycle_count !== 24'd11) begin
      failures++; $display("FAIL press_in_run got=%0d/%0d exp=2/11", state_dbg, cycle_count);
    end
    resetn = 1'b0;
    #2;
    checks++; if (state_dbg !== 3'd0 || busy !== 1'b0 || cycle_count !== 24'd0 || result !== 4'd10) begin
      failures++; $display("FAIL reset_mid_run got=%0d/%0d/%0d/%0d exp=0/0/0/10", state_dbg, busy, cycle_count, result);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    cyc(4);
    do_press();
    checks++; if (nn_start !== 1'b1) begin failures++; $display("FAIL start_after_reset got=%0d exp=1", nn_start); end
    resetn = 1'b0;
    #2;
    checks++; if (nn_start !== 1'b0 || state_dbg !== 3'd0) begin
      failures++; $display("FAIL async_start_drop got=%0d/%0d exp=0/0", nn_start, state_dbg);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_press_latency();
    test_run_result();
    test_timeout();
    test_blank_and_auto();
    test_clear_vs_press();
    test_press_in_run_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
